arm_fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage ARM core. It is the initiator on the instruction-memory interface: it owns the PC register, drives the fetch address and latches the returned word into the IF/ID pipeline register. It handles freeze (hazard stall), taken-branch redirect/flush from EX, and out-of-range fetch faults, and keeps a retired-fetch counter.

---
 rtl/arm_fetch_stage_if.sv | 9 +
 rtl/arm_fetch_stage.sv | 97 +++++++++
 tb/tb_arm_fetch_stage.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/arm_fetch_stage_if.sv
// Instruction-memory bus between the fetch stage (master) and imem (slave).
// Signals: PC (fetch address from master), Instruction (word returned same cycle).
interface arm_fetch_stage_if;
    logic [31:0] PC;
    logic [31:0] Instruction;

    modport master (output PC, input Instruction);
    modport slave (input PC, output Instruction);
endinterface

// File: rtl/arm_fetch_stage.sv
// ARM IF stage: PC register, imem fetch, IF/ID register, redirect, fault.
// Ports: clk, rst_n, freeze, branch_taken, branch_addr, imem (master bus),
//   IF/ID outputs if_pc_plus4/if_instruction/if_valid, fetch_fault,
//   halted, fetch_count. Optional halt detection: define HALT_DETECT_EN.
module arm_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter logic [31:0] IMEM_BYTES = 32'd1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      freeze,
    input  logic                      branch_taken,
    input  logic [31:0]               branch_addr,
    arm_fetch_stage_if.master         imem,
    output logic [31:0]               if_pc_plus4,
    output logic [31:0]               if_instruction,
    output logic                      if_valid,
    output logic                      fetch_fault,
    output logic                      halted,
    output logic [31:0]               fetch_count
);

    localparam logic [31:0] HALT_WORD = 32'hEAFF_FFFF;

    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        stopped;

    assign imem.PC  = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    // Misaligned targets are word-aligned by masking the low bits.
    assign target   = branch_addr & ~32'd3;

`ifdef HALT_DETECT_EN
    logic halted_q;
    logic is_halt;

    assign halted  = halted_q;
    assign is_halt = (imem.Instruction == HALT_WORD);
    assign stopped = fetch_fault | halted_q;
`else
    assign halted  = 1'b0;
    assign stopped = fetch_fault;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q           <= RESET_PC;
            if_pc_plus4    <= 32'd0;
            if_instruction <= 32'd0;
            if_valid       <= 1'b0;
            fetch_fault    <= 1'b0;
            fetch_count    <= 32'd0;
`ifdef HALT_DETECT_EN
            halted_q       <= 1'b0;
`endif
        end else if (branch_taken) begin
            // Redirect beats freeze; the word fetched this edge is wrong-path.
            pc_q           <= target;
            if_pc_plus4    <= 32'd0;
            if_instruction <= 32'd0;
            if_valid       <= 1'b0;
            fetch_fault    <= 1'b0;
`ifdef HALT_DETECT_EN
            halted_q       <= 1'b0;
`endif
        end else if (freeze) begin
            pc_q <= pc_q;
        end else if (stopped) begin
            if_pc_plus4    <= 32'd0;
            if_instruction <= 32'd0;
            if_valid       <= 1'b0;
        end else if (pc_q >= IMEM_BYTES) begin
            fetch_fault    <= 1'b1;
            if_pc_plus4    <= 32'd0;
            if_instruction <= 32'd0;
            if_valid       <= 1'b0;
        end else begin
            if_instruction <= imem.Instruction;
            if_pc_plus4    <= pc_plus4;
            if_valid       <= 1'b1;
            fetch_count    <= fetch_count + 32'd1;
`ifdef HALT_DETECT_EN
            // The halt word is delivered once, then PC parks on it.
            if (is_halt) begin
                halted_q <= 1'b1;
            end else begin
                pc_q <= pc_plus4;
            end
`else
            pc_q <= pc_plus4;
`endif
        end
    end

endmodule

// File: tb/tb_arm_fetch_stage.sv
// Directed bench for arm_fetch_stage with a tiny combinational imem model.
// Memory word = 32'hE3A00014 at 0, halt word at 184 when enabled, else E0000000|addr.
module tb_arm_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instruction;
    logic        if_valid;
    logic        fetch_fault;
    logic        halted;
    logic [31:0] fetch_count;
    logic        halt_en;

    int n_checks = 0;
    int n_errors = 0;

    arm_fetch_stage_if bus ();

    always #5 clk = ~clk;

    assign bus.Instruction =
        (bus.PC == 32'd0) ? 32'hE3A0_0014 :
        (halt_en && bus.PC == 32'd184) ? 32'hEAFF_FFFF :
        (32'hE000_0000 | bus.PC);

    arm_fetch_stage #(
        .RESET_PC   (32'd0),
        .IMEM_BYTES (32'd1024)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .freeze         (freeze),
        .branch_taken   (branch_taken),
        .branch_addr    (branch_addr),
        .imem           (bus.master),
        .if_pc_plus4    (if_pc_plus4),
        .if_instruction (if_instruction),
        .if_valid       (if_valid),
        .fetch_fault    (fetch_fault),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [31:0] p4,
                            input logic v, input logic [31:0] cnt);
        chk({tag, ".pc"}, bus.PC, pc);
        chk({tag, ".ins"}, if_instruction, ins);
        chk({tag, ".p4"}, if_pc_plus4, p4);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
        chk({tag, ".count"}, fetch_count, cnt);
    endtask

    initial begin
        int base;
        rst_n        = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'd0;
        halt_en      = 1'b0;

        #2;
        chk_ifid("reset", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        chk("reset.fault", {31'd0, fetch_fault}, 32'd0);
        chk("reset.halted", {31'd0, halted}, 32'd0);

        tick();
        rst_n = 1'b1;
        tick();
        chk_ifid("first", 32'd4, 32'hE3A0_0014, 32'd4, 1'b1, 32'd1);

        tick();
        tick();
        chk_ifid("run8", 32'd12, 32'hE000_0008, 32'd12, 1'b1, 32'd3);

        freeze = 1'b1;
        tick();
        tick();
        tick();
        chk_ifid("freeze", 32'd12, 32'hE000_0008, 32'd12, 1'b1, 32'd3);
        freeze = 1'b0;
        tick();
        chk_ifid("unfreeze", 32'd16, 32'hE000_000C, 32'd16, 1'b1, 32'd4);

        branch_taken = 1'b1;
        branch_addr  = 32'h0000_0073;
        freeze       = 1'b1;
        tick();
        chk_ifid("branch", 32'h70, 32'd0, 32'd0, 1'b0, 32'd4);
        branch_taken = 1'b0;
        freeze       = 1'b0;
        tick();
        chk_ifid("target", 32'h74, 32'hE000_0070, 32'h74, 1'b1, 32'd5);

        branch_taken = 1'b1;
        branch_addr  = 32'h3F8;
        tick();
        branch_taken = 1'b0;
        tick();
        tick();
        chk_ifid("edge", 32'h400, 32'hE000_03FC, 32'h400, 1'b1, 32'd7);
        tick();
        chk_ifid("fault1", 32'h400, 32'd0, 32'd0, 1'b0, 32'd7);
        chk("fault1.flag", {31'd0, fetch_fault}, 32'd1);
        tick();
        chk_ifid("fault2", 32'h400, 32'd0, 32'd0, 1'b0, 32'd7);
        chk("fault2.flag", {31'd0, fetch_fault}, 32'd1);
        branch_taken = 1'b1;
        branch_addr  = 32'd0;
        tick();
        chk_ifid("clrfault", 32'd0, 32'd0, 32'd0, 1'b0, 32'd7);
        chk("clrfault.flag", {31'd0, fetch_fault}, 32'd0);
        branch_taken = 1'b0;
        tick();
        chk_ifid("refetch", 32'd4, 32'hE3A0_0014, 32'd4, 1'b1, 32'd8);

        halt_en      = 1'b1;
        branch_taken = 1'b1;
        branch_addr  = 32'd184;
        tick();
        branch_taken = 1'b0;
        chk_ifid("tohalt", 32'd184, 32'd0, 32'd0, 1'b0, 32'd8);
        tick();
`ifdef HALT_DETECT_EN
        chk_ifid("halt", 32'd184, 32'hEAFF_FFFF, 32'd188, 1'b1, 32'd9);
        chk("halt.flag", {31'd0, halted}, 32'd1);
        tick();
        chk_ifid("halted", 32'd184, 32'd0, 32'd0, 1'b0, 32'd9);
        chk("halted.flag", {31'd0, halted}, 32'd1);
        base = 9;
`else
        chk_ifid("halt", 32'd188, 32'hEAFF_FFFF, 32'd188, 1'b1, 32'd9);
        chk("halt.flag", {31'd0, halted}, 32'd0);
        tick();
        chk_ifid("nohalt", 32'd192, 32'hE000_00BC, 32'd192, 1'b1, 32'd10);
        base = 10;
`endif
        halt_en      = 1'b0;
        branch_taken = 1'b1;
        branch_addr  = 32'h50;
        tick();
        branch_taken = 1'b0;
        chk_ifid("escape", 32'h50, 32'd0, 32'd0, 1'b0, base);
        chk("escape.flag", {31'd0, halted}, 32'd0);
        tick();
        tick();
        chk_ifid("pre_rst", 32'd88, 32'hE000_0054, 32'd88, 1'b1, base + 2);

        #2;
        rst_n = 1'b0;
        #1;
        chk_ifid("async_rst", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_ifid("post_rst", 32'd4, 32'hE3A0_0014, 32'd4, 1'b1, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
